// File: rtl/adpll_tx_pkg.sv
// Shared constants and types for the ADPLL TX modulation framer.
// Holds the mode encodings, framer FSM states and default symbol timing.
package adpll_tx_pkg;

  localparam logic [1:0] MODE_PD   = 2'd0;
  localparam logic [1:0] MODE_TEST = 2'd1;
  localparam logic [1:0] MODE_RX   = 2'd2;
  localparam logic [1:0] MODE_TX   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_PRE       = 2'd2,
    ST_DATA      = 2'd3
  } state_e;

  localparam int         DEF_BIT_CLKS = 32;
  localparam logic [7:0] DEF_PREAMBLE = 8'hAA;

endpackage

// File: rtl/adpll_tx_bitclk.sv
// Symbol-timing counter: bit_tick marks the last reference clock of each symbol.
// The counter idles at zero whenever it is not running or is restarted.
module adpll_tx_bitclk #(
  parameter int BIT_CLKS = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);

  logic [CW-1:0] clk_cnt_r;

  // Count 0..BIT_CLKS-1 while running, hold at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_r <= {CW{1'b0}};
    end else if (restart || !run) begin
      clk_cnt_r <= {CW{1'b0}};
    end else if (clk_cnt_r == LAST) begin
      clk_cnt_r <= {CW{1'b0}};
    end else begin
      clk_cnt_r <= clk_cnt_r + CW'(1);
    end
  end

  assign bit_tick = run && (clk_cnt_r == LAST);

endmodule

// File: rtl/adpll_tx_framer.sv
// ADPLL TX framer: waits for channel lock, then shifts preamble and payload
// bytes LSB first onto data_mod, one bit per BIT_CLKS reference clocks.
module adpll_tx_framer
  import adpll_tx_pkg::*;
#(
  parameter int         BIT_CLKS  = DEF_BIT_CLKS,
  parameter logic [7:0] PREAMBLE  = DEF_PREAMBLE,
  parameter int         PRE_BYTES = 1,
  parameter int         LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       adpll_mode,
  input  logic             channel_lock,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             data_mod,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic             underrun
);

  localparam int PRE_BITS = PRE_BYTES * 8;
  localparam int BC_W     = $clog2(PRE_BITS);

  state_e           state_r, state_s;
  logic             data_mod_r, data_mod_s;
  logic [BC_W-1:0]  bit_cnt_r, bit_cnt_s, nxt_bit_s;
  logic [7:0]       shift_r, shift_s;
  logic [7:0]       hold_r, hold_s;
  logic             hold_full_r, hold_full_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic [LEN_W-1:0] fetched_r, fetched_s;
  logic [LEN_W-1:0] sent_r, sent_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             abort_r, abort_s;
  logic             underrun_r, underrun_s;

  logic bit_tick_s, run_s, restart_s, mode_ok_s, sending_s;
  logic byte_ready_s, xfer_s, boundary_s, more_s, underrun_c_s, abort_c_s;

  assign sending_s = (state_r == ST_PRE) || (state_r == ST_DATA);
  assign run_s     = sending_s;
  assign restart_s = (state_r == ST_WAIT_LOCK) && channel_lock;

  adpll_tx_bitclk #(.BIT_CLKS(BIT_CLKS)) u_bitclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run_s),
    .restart  (restart_s),
    .bit_tick (bit_tick_s)
  );

  assign mode_ok_s    = en && (adpll_mode == MODE_TX);
  assign byte_ready_s = busy_r && !hold_full_r && (fetched_r < len_r);
  assign xfer_s       = byte_valid && byte_ready_s;
  assign nxt_bit_s    = bit_cnt_r + BC_W'(1);
  // A byte boundary is the end of the preamble or the end of a payload byte.
  assign boundary_s   = bit_tick_s &&
                        (((state_r == ST_PRE)  && (bit_cnt_r == BC_W'(PRE_BITS - 1))) ||
                         ((state_r == ST_DATA) && (bit_cnt_r == BC_W'(7))));
  assign more_s       = (sent_r != len_r);
  assign underrun_c_s = boundary_s && more_s && !hold_full_r;
  assign abort_c_s    = (state_r != ST_IDLE) &&
                        (!mode_ok_s || (sending_s && !channel_lock) || underrun_c_s);

  // Next-state and next-output logic for the framer.
  always_comb begin
    state_s     = state_r;
    data_mod_s  = data_mod_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    len_s       = len_r;
    fetched_s   = fetched_r;
    sent_s      = sent_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    underrun_s  = 1'b0;

    if (xfer_s) begin
      hold_s      = byte_data;
      hold_full_s = 1'b1;
      fetched_s   = fetched_r + LEN_W'(1);
    end else begin
      hold_s      = hold_r;
    end

    if (abort_c_s) begin
      state_s     = ST_IDLE;
      data_mod_s  = 1'b0;
      hold_full_s = 1'b0;
      busy_s      = 1'b0;
      abort_s     = 1'b1;
      underrun_s  = underrun_c_s;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && mode_ok_s) begin
            state_s     = ST_WAIT_LOCK;
            len_s       = len;
            fetched_s   = {LEN_W{1'b0}};
            sent_s      = {LEN_W{1'b0}};
            hold_full_s = 1'b0;
            busy_s      = 1'b1;
          end else begin
            state_s     = ST_IDLE;
          end
        end
        ST_WAIT_LOCK: begin
          if (channel_lock) begin
            state_s    = ST_PRE;
            data_mod_s = PREAMBLE[0];
            bit_cnt_s  = {BC_W{1'b0}};
          end else begin
            state_s    = ST_WAIT_LOCK;
          end
        end
        ST_PRE, ST_DATA: begin
          if (boundary_s) begin
            if (!more_s) begin
              state_s    = ST_IDLE;
              data_mod_s = 1'b0;
              busy_s     = 1'b0;
              done_s     = 1'b1;
            end else begin
              state_s     = ST_DATA;
              shift_s     = hold_r;
              data_mod_s  = hold_r[0];
              bit_cnt_s   = {BC_W{1'b0}};
              sent_s      = sent_r + LEN_W'(1);
              hold_full_s = 1'b0;
            end
          end else if (bit_tick_s) begin
            bit_cnt_s = nxt_bit_s;
            if (state_r == ST_PRE) begin
              data_mod_s = PREAMBLE[nxt_bit_s[2:0]];
            end else begin
              data_mod_s = shift_r[1];
              shift_s    = {1'b0, shift_r[7:1]};
            end
          end else begin
            bit_cnt_s = bit_cnt_r;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          data_mod_s = 1'b0;
          busy_s     = 1'b0;
        end
      endcase
    end
  end

  // Framer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      data_mod_r  <= 1'b0;
      bit_cnt_r   <= {BC_W{1'b0}};
      shift_r     <= 8'h00;
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      len_r       <= {LEN_W{1'b0}};
      fetched_r   <= {LEN_W{1'b0}};
      sent_r      <= {LEN_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      abort_r     <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      data_mod_r  <= data_mod_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      len_r       <= len_s;
      fetched_r   <= fetched_s;
      sent_r      <= sent_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      abort_r     <= abort_s;
      underrun_r  <= underrun_s;
    end
  end

  assign byte_ready = byte_ready_s;
  assign data_mod   = data_mod_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign abort      = abort_r;
  assign underrun   = underrun_r;

endmodule

// File: tb/tb_adpll_tx_framer.sv
// Directed bench for adpll_tx_framer: frame timing, prefetch, lock wait,
// underrun, abort causes and asynchronous reset, against hand-computed bit patterns.
module tb_adpll_tx_framer;

  localparam int BIT_CLKS = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] adpll_mode = 2'd0;
  logic       channel_lock = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready, data_mod, busy, done, abort, underrun;

  int checks = 0;
  int errors = 0;
  logic ready_seen, abort_seen, done_seen;

  logic [7:0] host_q[$];
  bit         xfer_pend = 1'b0;

  adpll_tx_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .adpll_mode   (adpll_mode),
    .channel_lock (channel_lock),
    .start        (start),
    .len          (len),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .data_mod     (data_mod),
    .busy         (busy),
    .done         (done),
    .abort        (abort),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Host model: offers the head of host_q, pops it once a transfer has happened.
  always @(negedge clk) begin
    if (xfer_pend && host_q.size() > 0) void'(host_q.pop_front());
    byte_valid = (host_q.size() > 0);
    byte_data  = (host_q.size() > 0) ? host_q[0] : 8'h00;
    xfer_pend  = byte_valid && byte_ready;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] n);
    len   = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge right after PRE entry; checks each bit at both ends of its period.
  task automatic check_frame(input string name, input int nbits, input logic [39:0] pat);
    logic [39:0] p;
    p = pat;
    ready_seen = 1'b0; abort_seen = 1'b0; done_seen = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (c == 0 || c == BIT_CLKS - 1)
          check_val($sformatf("%s_bit%0d_c%0d", name, k, c), {31'd0, data_mod}, {31'd0, p[k]});
        ready_seen |= byte_ready;
        abort_seen |= abort;
        done_seen  |= done;
        @(negedge clk);
      end
    end
    check_val({name, "_done"}, {31'd0, done}, 32'd1);
    check_val({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    check_val({name, "_dm_end"}, {31'd0, data_mod}, 32'd0);
    check_val({name, "_no_abort"}, {31'd0, abort_seen}, 32'd0);
    check_val({name, "_no_early_done"}, {31'd0, done_seen}, 32'd0);
    @(negedge clk);
    check_val({name, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_ready", {31'd0, byte_ready}, 32'd0);
    check_val("rst_dm", {31'd0, data_mod}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_abort", {31'd0, abort}, 32'd0);
    check_val("rst_underrun", {31'd0, underrun}, 32'd0);
    rst_n = 1'b1; en = 1'b1; adpll_mode = 2'd3; channel_lock = 1'b1;
    @(negedge clk);

    // Two-byte frame with lock already present and bytes preloaded.
    host_q.push_back(8'h0F); host_q.push_back(8'hF0);
    start_frame(8'd2);
    check_val("t1_busy", {31'd0, busy}, 32'd1);
    check_val("t1_dm_wait", {31'd0, data_mod}, 32'd0);
    @(negedge clk);
    check_frame("t1", 24, {16'h0, 8'hF0, 8'h0F, 8'hAA});

    // Empty payload: preamble only, never requests a byte.
    start_frame(8'd0);
    @(negedge clk);
    check_frame("t2", 8, {32'h0, 8'hAA});
    check_val("t2_no_ready", {31'd0, ready_seen}, 32'd0);

    // Lock arrives late.
    channel_lock = 1'b0;
    host_q.push_back(8'h3C);
    start_frame(8'd1);
    abort_seen = 1'b0;
    repeat (100) begin
      abort_seen |= abort;
      @(negedge clk);
    end
    check_val("t3_dm_wait", {31'd0, data_mod}, 32'd0);
    check_val("t3_busy_wait", {31'd0, busy}, 32'd1);
    check_val("t3_no_abort", {31'd0, abort_seen}, 32'd0);
    channel_lock = 1'b1;
    @(negedge clk);
    check_frame("t3", 16, {24'h0, 8'h3C, 8'hAA});

    // Underrun: only two of three bytes supplied.
    host_q.push_back(8'h12); host_q.push_back(8'h34);
    start_frame(8'd3);
    @(negedge clk);
    repeat (24 * BIT_CLKS - 1) @(negedge clk);
    check_val("t4_abort_early", {31'd0, abort}, 32'd0);
    @(negedge clk);
    check_val("t4_abort", {31'd0, abort}, 32'd1);
    check_val("t4_underrun", {31'd0, underrun}, 32'd1);
    check_val("t4_dm", {31'd0, data_mod}, 32'd0);
    check_val("t4_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check_val("t4_busy", {31'd0, busy}, 32'd0);
    check_val("t4_abort_pulse", {31'd0, abort}, 32'd0);
    host_q.delete();

    // Lock drop mid-payload.
    host_q.push_back(8'hAB); host_q.push_back(8'hCD);
    start_frame(8'd2);
    @(negedge clk);
    repeat (8 * BIT_CLKS + 40) @(negedge clk);
    check_val("t5a_busy_pre", {31'd0, busy}, 32'd1);
    channel_lock = 1'b0;
    @(negedge clk);
    check_val("t5a_abort", {31'd0, abort}, 32'd1);
    check_val("t5a_underrun", {31'd0, underrun}, 32'd0);
    check_val("t5a_dm", {31'd0, data_mod}, 32'd0);
    check_val("t5a_busy", {31'd0, busy}, 32'd0);
    channel_lock = 1'b1;
    @(negedge clk);
    check_val("t5a_abort_pulse", {31'd0, abort}, 32'd0);
    host_q.delete();

    // Mode switched to RX during preamble bit 1 (data_mod high), then a clean frame.
    host_q.push_back(8'h5A);
    start_frame(8'd1);
    @(negedge clk);
    repeat (50) @(negedge clk);
    check_val("t5b_dm_pre", {31'd0, data_mod}, 32'd1);
    adpll_mode = 2'd2;
    @(negedge clk);
    check_val("t5b_abort", {31'd0, abort}, 32'd1);
    check_val("t5b_underrun", {31'd0, underrun}, 32'd0);
    check_val("t5b_dm", {31'd0, data_mod}, 32'd0);
    check_val("t5b_busy", {31'd0, busy}, 32'd0);
    adpll_mode = 2'd3;
    host_q.delete();
    @(negedge clk);
    host_q.push_back(8'hC3);
    start_frame(8'd1);
    @(negedge clk);
    check_frame("t5c", 16, {24'h0, 8'hC3, 8'hAA});

    // Asynchronous reset mid-preamble.
    start_frame(8'd0);
    @(negedge clk);
    repeat (40) @(negedge clk);
    check_val("t6_dm_pre", {31'd0, data_mod}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("t6_dm", {31'd0, data_mod}, 32'd0);
    check_val("t6_busy", {31'd0, busy}, 32'd0);
    check_val("t6_ready", {31'd0, byte_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0; abort_seen = 1'b0;
    repeat (300) begin
      done_seen  |= done;
      abort_seen |= abort;
      @(negedge clk);
    end
    check_val("t6_no_done", {31'd0, done_seen}, 32'd0);
    check_val("t6_no_abort", {31'd0, abort_seen}, 32'd0);
    adpll_mode = 2'd2;
    start_frame(8'd1);
    check_val("t6_rx_busy0", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check_val("t6_rx_busy1", {31'd0, busy}, 32'd0);
    check_val("t6_rx_dm", {31'd0, data_mod}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
